// File: rtl/fir_inverse.sv
// Inverse of the first-order recursive filter y = a*x + b*y[-1]. It recovers x from the
// y stream, with a = 2^A_LOG2, and queues results in a 2-entry output buffer.
//
// state    | meaning
// ST_EMPTY | no history yet; the next accepted y_in only primes y_prev
// ST_RUN   | history valid; each accepted y_in yields one buffered result
module fir_inverse #(
  parameter int                A_LOG2 = 1,
  parameter logic signed [7:0] B_COEF = 8'sd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_valid,
  input  logic [7:0]  y_init,
  input  logic [7:0]  y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  x_out,
  output logic        x_inexact,
  output logic        x_sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sample_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic signed [15:0] B_EXT    = 16'(B_COEF);
  localparam logic [16:0]        REM_MASK = (17'd1 << A_LOG2) - 17'd1;

  state_t             state_q, state_d;
  logic signed [7:0]  y_prev_q, y_prev_d;
  logic [1:0]         count_q, count_d;
  logic [9:0]         buf0_q, buf0_d, buf1_q, buf1_d;
  logic [15:0]        sample_cnt_q, sample_cnt_d;

  logic               accept, pop, produce;
  logic signed [7:0]  y_base;
  logic signed [15:0] prod;
  logic signed [16:0] diff, quot;
  logic               inexact, sat;
  logic [7:0]         x_val;
  logic [9:0]         entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      y_prev_q     <= '0;
      count_q      <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      y_prev_q     <= y_prev_d;
      count_q      <= count_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready   = (state_q == ST_EMPTY) || (count_q < 2'd2);
    out_valid  = (count_q != 2'd0);
    x_out      = buf0_q[9:2];
    x_inexact  = buf0_q[1];
    x_sat      = buf0_q[0];
    sample_cnt = sample_cnt_q;
  end

  always_comb begin
    accept  = in_valid & in_ready;
    pop     = out_valid & out_ready;
    produce = accept & ((state_q == ST_RUN) | init_valid);

    state_d = state_q;
    if (init_valid | accept) state_d = ST_RUN;

    y_prev_d = y_prev_q;
    if (accept)          y_prev_d = $signed(y_in);
    else if (init_valid) y_prev_d = $signed(y_init);
  end

  // A seed arriving with a sample is used as that sample's history.
  always_comb begin
    y_base  = init_valid ? $signed(y_init) : y_prev_q;
    prod    = B_EXT * 16'(y_base);
    diff    = 17'($signed(y_in)) - 17'(prod);
    quot    = diff >>> A_LOG2;
    inexact = |(diff & REM_MASK);
    if (quot > 17'sd127) begin
      x_val = 8'h7F;
      sat   = 1'b1;
    end else if (quot < -17'sd128) begin
      x_val = 8'h80;
      sat   = 1'b1;
    end else begin
      x_val = quot[7:0];
      sat   = 1'b0;
    end
    entry = {x_val, inexact, sat};
  end

  always_comb begin
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    count_d      = count_q;
    sample_cnt_d = sample_cnt_q + 16'(pop);
    case ({produce, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = entry;
        else                 buf1_d = entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = entry;
        end else begin
          buf0_d = buf1_q;
          buf1_d = entry;
        end
      end
      default: ;
    endcase
  end

endmodule
